ahb_manager_input_stage: RTL and testbench

- Per-manager requester stage that sits between one AHB-Lite manager and the shared-bus mux.
- It is the requesting end of the fixed-priority arbiter: it raises Request, waits for Grant, and holds the manager's pending address phase while access is denied.
- When Grant arrives, it replays the held address phase onto the shared bus.
- It tracks data-phase ownership so the interconnect can route HWDATA, HRDATA and HREADY back to this manager.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/flopenr.sv | 20 ++
 rtl/ahb_manager_input_stage.sv | 106 ++++++++++
 tb/tb_ahb_manager_input_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the manager input stage: HTRANS codes,
// the captured address-phase record and the requester state encoding.
package ahb_pkg;

  localparam int AHB_ADDR_WIDTH = 32;
  localparam int AHB_PROT_WIDTH = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef struct packed {
    logic [AHB_ADDR_WIDTH-1:0] haddr;
    logic                      hwrite;
    logic [2:0]                hsize;
    logic [2:0]                hburst;
    logic [AHB_PROT_WIDTH-1:0] hprot;
  } ahb_addr_phase_t;

  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-low reset to zero.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ahb_manager_input_stage.sv
// Per-manager requester stage: requests the shared bus, parks one denied
// address phase and replays it on grant. Widths must match ahb_pkg.
module ahb_manager_input_stage
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
  parameter int PROT_WIDTH = AHB_PROT_WIDTH
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] HADDRIn,
  input  logic [1:0]            HTRANSIn,
  input  logic                  HWRITEIn,
  input  logic [2:0]            HSIZEIn,
  input  logic [2:0]            HBURSTIn,
  input  logic [PROT_WIDTH-1:0] HPROTIn,
  output logic                  HREADYOutM,
  output logic                  Request,
  input  logic                  Grant,
  input  logic                  HREADYIn,
  output logic [ADDR_WIDTH-1:0] HADDROut,
  output logic [1:0]            HTRANSOut,
  output logic                  HWRITEOut,
  output logic [2:0]            HSIZEOut,
  output logic [2:0]            HBURSTOut,
  output logic [PROT_WIDTH-1:0] HPROTOut,
  output logic                  DataPhaseOwner
);

  state_t          state, state_next;
  ahb_addr_phase_t live_phase, held_phase, sel_phase;
  logic [1:0]      held_trans, sel_trans;
  logic            capture;
  logic            owner;

  assign live_phase = '{haddr:  HADDRIn,
                        hwrite: HWRITEIn,
                        hsize:  HSIZEIn,
                        hburst: HBURSTIn,
                        hprot:  HPROTIn};

  flopenr #(.WIDTH($bits(ahb_addr_phase_t))) u_held_phase (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .en    (capture),
    .d     (live_phase),
    .q     (held_phase)
  );

  flopenr #(.WIDTH(2)) u_held_trans (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .en    (capture),
    .d     (HTRANSIn),
    .q     (held_trans)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= PASS;
      owner <= 1'b0;
    end else begin
      state <= state_next;
      if (HREADYIn) begin
        owner <= Grant & HTRANSOut[1];
      end
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    sel_phase  = live_phase;
    sel_trans  = HTRANSIn;
    Request    = HTRANSIn[1];
    HREADYOutM = owner ? HREADYIn : 1'b1;
    case (state)
      PASS: begin
        // Grant with HREADYIn low counts as no grant, so the phase is parked.
        if (HTRANSIn[1] && HREADYOutM && !(Grant && HREADYIn)) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        sel_phase  = held_phase;
        sel_trans  = held_trans;
        Request    = 1'b1;
        HREADYOutM = 1'b0;
        if (Grant && HREADYIn) begin
          state_next = PASS;
        end
      end
      default: state_next = PASS;
    endcase
    HTRANSOut = Grant ? sel_trans : HTRANS_IDLE;
  end

  assign HADDROut       = sel_phase.haddr;
  assign HWRITEOut      = sel_phase.hwrite;
  assign HSIZEOut       = sel_phase.hsize;
  assign HBURSTOut      = sel_phase.hburst;
  assign HPROTOut       = sel_phase.hprot;
  assign DataPhaseOwner = owner;

endmodule

// File: tb/tb_ahb_manager_input_stage.sv
// Directed plus randomized bench for ahb_manager_input_stage, checked against
// a transaction-level model holding at most one parked transfer in a queue.
module tb_ahb_manager_input_stage;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDRIn;
  logic [1:0]  HTRANSIn;
  logic        HWRITEIn;
  logic [2:0]  HSIZEIn;
  logic [2:0]  HBURSTIn;
  logic [3:0]  HPROTIn;
  logic        HREADYOutM;
  logic        Request;
  logic        Grant;
  logic        HREADYIn;
  logic [31:0] HADDROut;
  logic [1:0]  HTRANSOut;
  logic        HWRITEOut;
  logic [2:0]  HSIZEOut;
  logic [2:0]  HBURSTOut;
  logic [3:0]  HPROTOut;
  logic        DataPhaseOwner;

  ahb_manager_input_stage #(.ADDR_WIDTH(32), .PROT_WIDTH(4)) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .HADDRIn        (HADDRIn),
    .HTRANSIn       (HTRANSIn),
    .HWRITEIn       (HWRITEIn),
    .HSIZEIn        (HSIZEIn),
    .HBURSTIn       (HBURSTIn),
    .HPROTIn        (HPROTIn),
    .HREADYOutM     (HREADYOutM),
    .Request        (Request),
    .Grant          (Grant),
    .HREADYIn       (HREADYIn),
    .HADDROut       (HADDROut),
    .HTRANSOut      (HTRANSOut),
    .HWRITEOut      (HWRITEOut),
    .HSIZEOut       (HSIZEOut),
    .HBURSTOut      (HBURSTOut),
    .HPROTOut       (HPROTOut),
    .DataPhaseOwner (DataPhaseOwner)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending transfer queue (0 or 1 entries) and data-phase ownership.
  xfer_t pend[$];
  bit    m_owner;
  bit    e_rdy, e_req;
  logic [1:0] e_trans;
  xfer_t e_sel;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t live();
    return '{addr: HADDRIn, trans: HTRANSIn, write: HWRITEIn,
             size: HSIZEIn, burst: HBURSTIn, prot: HPROTIn};
  endfunction

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic w,
                       input logic g, input logic r);
    HTRANSIn = t; HADDRIn = a; HWRITEIn = w; HSIZEIn = 3'd2;
    HBURSTIn = 3'd0; HPROTIn = 4'h3; Grant = g; HREADYIn = r;
  endtask

  task automatic model_reset();
    pend.delete();
    m_owner = 0;
  endtask

  // Settle, then compare every output against the model.
  task automatic sample();
    xfer_t cur;
    #1;
    cur     = live();
    e_sel   = (pend.size() != 0) ? pend[0] : cur;
    e_req   = (pend.size() != 0) || cur.trans[1];
    e_rdy   = (pend.size() != 0) ? 1'b0 : (m_owner ? HREADYIn : 1'b1);
    e_trans = Grant ? e_sel.trans : 2'b00;
    check("request",   64'(Request),        64'(e_req));
    check("hreadym",   64'(HREADYOutM),     64'(e_rdy));
    check("htrans",    64'(HTRANSOut),      64'(e_trans));
    check("owner",     64'(DataPhaseOwner), 64'(m_owner));
    check("addrphase", {HADDROut, HWRITEOut, HSIZEOut, HBURSTOut, HPROTOut},
          {e_sel.addr, e_sel.write, e_sel.size, e_sel.burst, e_sel.prot});
  endtask

  // Apply the clock edge to the model, then move to the next drive point.
  task automatic advance();
    xfer_t cur;
    cur = live();
    if (HREADYIn) m_owner = Grant && e_trans[1];
    if (pend.size() != 0) begin
      if (Grant && HREADYIn) pend.delete();
    end else if (cur.trans[1] && e_rdy && !(Grant && HREADYIn)) begin
      pend.push_back(cur);
    end
    @(negedge HCLK);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    model_reset();
    repeat (2) @(negedge HCLK);
    sample();
    check("rst_request", 64'(Request), 64'd0);
    check("rst_hreadym", 64'(HREADYOutM), 64'd1);
    check("rst_htrans",  64'(HTRANSOut), 64'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // 1: granted NONSEQ passes straight through
    drive(2'b10, 32'h1000, 1'b1, 1'b1, 1'b1);
    sample();
    check("t1_htrans", 64'(HTRANSOut), 64'd2);
    check("t1_addr",   64'(HADDROut), 64'h1000);
    advance();
    drive(2'b00, 32'h0, 1'b0, 1'b1, 1'b1);
    sample();
    check("t1_owner", 64'(DataPhaseOwner), 64'd1);
    advance();
    step();

    // 2: denied NONSEQ is parked, replayed on grant three cycles later
    drive(2'b10, 32'h2000, 1'b0, 1'b0, 1'b1);
    sample();
    check("t2_req", 64'(Request), 64'd1);
    advance();
    drive(2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    sample();
    check("t2_hold_rdy", 64'(HREADYOutM), 64'd0);
    advance();
    step();
    step();
    Grant = 1'b1;
    sample();
    check("t2_replay_addr",  64'(HADDROut), 64'h2000);
    check("t2_replay_trans", 64'(HTRANSOut), 64'd2);
    advance();
    sample();
    check("t2_owner", 64'(DataPhaseOwner), 64'd1);
    advance();

    // 3: grant lost at beat 3 of INCR4
    drive(2'b10, 32'h3000, 1'b1, 1'b1, 1'b1); HBURSTIn = 3'b011; step();
    drive(2'b11, 32'h3004, 1'b1, 1'b1, 1'b1); HBURSTIn = 3'b011; step();
    drive(2'b11, 32'h3008, 1'b1, 1'b0, 1'b1); HBURSTIn = 3'b011; step();
    drive(2'b11, 32'h300C, 1'b1, 1'b0, 1'b1); HBURSTIn = 3'b011; step();
    Grant = 1'b1;
    sample();
    check("t3_replay_addr",  64'(HADDROut), 64'h3008);
    check("t3_replay_trans", 64'(HTRANSOut), 64'd3);
    advance();
    sample();
    check("t3_beat4_addr", 64'(HADDROut), 64'h300C);
    advance();

    // 4: subordinate wait states during our data phase
    drive(2'b10, 32'h5000, 1'b0, 1'b1, 1'b1); step();
    drive(2'b10, 32'h5004, 1'b0, 1'b1, 1'b0);
    sample();
    check("t4_ws1_rdy", 64'(HREADYOutM), 64'd0);
    advance();
    sample();
    check("t4_ws2_owner", 64'(DataPhaseOwner), 64'd1);
    advance();
    HREADYIn = 1'b1;
    step();

    // 5: reset while holding 0x4000
    drive(2'b10, 32'h4000, 1'b0, 1'b0, 1'b1); step();
    drive(2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    sample();
    check("t5_holding", 64'(Request), 64'd1);
    HRESETn = 1'b0;
    model_reset();
    sample();
    check("t5_rst_req",   64'(Request), 64'd0);
    check("t5_rst_rdy",   64'(HREADYOutM), 64'd1);
    check("t5_rst_trans", 64'(HTRANSOut), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    Grant = 1'b1;
    sample();
    check("t5_no_replay", 64'(HTRANSOut), 64'd0);
    advance();

    // 6: IDLE and BUSY never captured or requested
    drive(2'b00, 32'h6000, 1'b0, 1'b0, 1'b1); step();
    drive(2'b01, 32'h6004, 1'b0, 1'b0, 1'b1);
    sample();
    check("t6_busy_req", 64'(Request), 64'd0);
    advance();
    drive(2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    sample();
    check("t6_no_hold", 64'(HREADYOutM), 64'd1);
    advance();

    // Random traffic; the manager only changes its request when accepted.
    for (int i = 0; i < 400; i++) begin
      if (e_rdy) begin
        HTRANSIn = 2'($urandom_range(0, 3));
        HADDRIn  = $urandom;
        HWRITEIn = 1'($urandom);
        HSIZEIn  = 3'($urandom);
        HBURSTIn = 3'($urandom);
        HPROTIn  = 4'($urandom);
      end
      Grant    = ($urandom_range(0, 3) != 0);
      HREADYIn = ($urandom_range(0, 4) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
